// File: rtl/latency_memory.sv
// latency_memory: single-port synchronous RAM with byte-lane writes and a
// configurable read latency (1..4) signalled by an rvalid pulse.
// Optional feature macro: MEM_ACCESS_CHECK_EN adds the sticky access_err
// output and run-time reporting of conflicting / out-of-range accesses.
// The array is not reset, so contents preloaded while reset is high survive.
module latency_memory #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid
`ifdef MEM_ACCESS_CHECK_EN
  ,
  output logic                    access_err
`endif
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  // Storage array; kept under this exact name for hierarchical preload.
  logic [DATA_WIDTH-1:0] ram [0:MEM_DEPTH-1];

  logic                    in_range;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Read pipeline: stage 0 captures the array word, the last stage drives dout.
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_dat_d [READ_LATENCY];

  // Request decode: a write always wins over a simultaneous read.
  always_comb begin
    in_range = (32'(addr) < MEM_DEPTH);
    rd_acc   = en & rd_en & ~wr_en;
    wr_acc   = en & wr_en & in_range;
    rd_word  = in_range ? ram[addr] : '0;
  end

  // Next-state of the read pipeline; each stage only reloads when fed a valid
  // entry, which makes the final stage (dout) hold between reads.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = rd_acc;
    if (rd_acc) begin
      pipe_dat_d[0] = rd_word;
    end
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      if (pipe_vld_q[i-1]) begin
        pipe_dat_d[i] = pipe_dat_q[i-1];
      end
    end
  end

  // Pipeline registers; reset flushes in-flight reads and clears dout.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_dat_q[i] <= '0;
      end
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_dat_q <= pipe_dat_d;
    end
  end

  // Byte-lane array write; ignored during reset and for out-of-range addresses.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (be[l]) begin
          ram[addr][8*l +: 8] <= din[8*l +: 8];
        end
      end
    end
  end

  // Output taps from the last pipeline stage.
  always_comb begin
    dout   = pipe_dat_q[READ_LATENCY-1];
    rvalid = pipe_vld_q[READ_LATENCY-1];
  end

`ifdef MEM_ACCESS_CHECK_EN
  logic access_err_q, access_err_d;

  // Sticky error: conflicting request or out-of-range address while enabled.
  always_comb begin
    access_err_d = access_err_q | (en & ((rd_en & wr_en) | ~in_range));
    access_err   = access_err_q;
  end

  // Error flag register plus run-time report of each offending access.
  always_ff @(posedge clock) begin
    if (reset) begin
      access_err_q <= 1'b0;
    end else begin
      access_err_q <= access_err_d;
      if (en && ((rd_en && wr_en) || !in_range)) begin
        $error("latency_memory: access violation at time %0t, addr 0x%0h", $time, addr);
      end
    end
  end
`endif

endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: four instances (READ_LATENCY 1..4, MEM_DEPTH 3000)
// share one stimulus stream. A reference array models the memory; every
// accepted read is pushed to a history scoreboard and each instance consumes
// it through its own read pointer when its latency expires.
module tb_latency_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        rd_en;
  logic        wr_en;
  logic [11:0] addr;
  logic [15:0] din;
  logic [1:0]  be;

  logic [15:0] dout_w   [4];
  logic        rvalid_w [4];
`ifdef MEM_ACCESS_CHECK_EN
  logic        err_w    [4];
`endif

  always #5 clock = ~clock;

  latency_memory #(.DATA_WIDTH(16), .MEM_DEPTH(3000), .ADDR_WIDTH(12), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .en(en), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .din(din), .be(be), .dout(dout_w[0]), .rvalid(rvalid_w[0])
`ifdef MEM_ACCESS_CHECK_EN
    , .access_err(err_w[0])
`endif
  );
  latency_memory #(.DATA_WIDTH(16), .MEM_DEPTH(3000), .ADDR_WIDTH(12), .READ_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .en(en), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .din(din), .be(be), .dout(dout_w[1]), .rvalid(rvalid_w[1])
`ifdef MEM_ACCESS_CHECK_EN
    , .access_err(err_w[1])
`endif
  );
  latency_memory #(.DATA_WIDTH(16), .MEM_DEPTH(3000), .ADDR_WIDTH(12), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .en(en), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .din(din), .be(be), .dout(dout_w[2]), .rvalid(rvalid_w[2])
`ifdef MEM_ACCESS_CHECK_EN
    , .access_err(err_w[2])
`endif
  );
  latency_memory #(.DATA_WIDTH(16), .MEM_DEPTH(3000), .ADDR_WIDTH(12), .READ_LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset), .en(en), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .din(din), .be(be), .dout(dout_w[3]), .rvalid(rvalid_w[3])
`ifdef MEM_ACCESS_CHECK_EN
    , .access_err(err_w[3])
`endif
  );

  // Reference state
  logic [15:0] model [0:2999];
  int          hist_cyc [$];
  logic [15:0] hist_dat [$];
  int          rd_idx   [4];
  logic [15:0] exp_dout [4];
  int          cyc;
  int          n_pass;
  int          n_total;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp_v);
  endtask

  // One clock edge: record what the current inputs mean, then compare outputs.
  task automatic tick();
    logic exp_v;
    cyc++;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        rd_idx[k]   = hist_cyc.size();
        exp_dout[k] = '0;
      end
    end else begin
      if (en && rd_en && !wr_en) begin
        hist_cyc.push_back(cyc);
        hist_dat.push_back((addr < 12'd3000) ? model[addr] : 16'h0000);
      end
      if (en && wr_en && addr < 12'd3000) begin
        for (int l = 0; l < 2; l++) begin
          if (be[l]) model[addr][l*8 +: 8] = din[l*8 +: 8];
        end
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_v = 1'b0;
      if (!reset && rd_idx[k] < hist_cyc.size() && hist_cyc[rd_idx[k]] + k == cyc) begin
        exp_v       = 1'b1;
        exp_dout[k] = hist_dat[rd_idx[k]];
        rd_idx[k]++;
      end
      check($sformatf("rvalid_L%0d_cyc%0d", k + 1, cyc), 16'(rvalid_w[k]), 16'(exp_v));
      check($sformatf("dout_L%0d_cyc%0d", k + 1, cyc), dout_w[k], exp_dout[k]);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rd, input logic wr,
                      input logic [11:0] a, input logic [15:0] d, input logic [1:0] b);
    reset = r; en = e; rd_en = rd; wr_en = wr; addr = a; din = d; be = b;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00);
  endtask

  task automatic preload();
    logic [15:0] v;
    for (int i = 0; i < 32; i++) begin
      v = (i == 16) ? 16'hBEEF : 16'h1000 + 16'(i);
      u_l1.ram[i] = v;
      u_l2.ram[i] = v;
      u_l3.ram[i] = v;
      u_l4.ram[i] = v;
      model[i]    = v;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      rd_idx[k] = 0; exp_dout[k] = '0;
    end
    reset = 1'b1; en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; din = '0; be = '0;

    // Reset with preload applied while reset is high
    preload();
    step(1, 0, 0, 0, 12'h000, 16'h0000, 2'b00);
    step(1, 0, 0, 0, 12'h000, 16'h0000, 2'b00);

    // Preloaded word survives reset
    step(0, 1, 1, 0, 12'h010, 16'h0000, 2'b00);
    idle(4);

    // Back-to-back reads of 0..7
    for (int a = 0; a < 8; a++) step(0, 1, 1, 0, 12'(a), 16'h0000, 2'b00);
    idle(5);

    // Byte lanes, with read-after-write in the next cycle
    step(0, 1, 0, 1, 12'h005, 16'hFFFF, 2'b11);
    step(0, 1, 0, 1, 12'h005, 16'h1234, 2'b01);
    step(0, 1, 1, 0, 12'h005, 16'h0000, 2'b00);
    step(0, 1, 0, 1, 12'h005, 16'h0000, 2'b00);
    step(0, 1, 1, 0, 12'h005, 16'h0000, 2'b00);
    idle(4);

    // Simultaneous read and write: write done, read dropped
    step(0, 1, 1, 1, 12'h007, 16'hAAAA, 2'b11);
    check("ram7_after_conflict", u_l1.ram[7], model[7]);
    check("ram7_after_conflict_L4", u_l4.ram[7], model[7]);
    step(0, 1, 1, 0, 12'h007, 16'h0000, 2'b00);
    idle(4);
`ifdef MEM_ACCESS_CHECK_EN
    check("access_err_after_conflict", 16'(err_w[0]), 16'h0001);
`endif

    // Out of range: write ignored, read returns zero with rvalid
    step(0, 1, 0, 1, 12'd3000, 16'h5555, 2'b11);
    step(0, 1, 1, 0, 12'd3000, 16'h0000, 2'b00);
    step(0, 1, 1, 0, 12'd2999 - 12'd2999 + 12'h002, 16'h0000, 2'b00);
    step(0, 1, 1, 0, 12'hFFF, 16'h0000, 2'b00);
    idle(5);

    // en low: request lines ignored
    step(0, 0, 1, 0, 12'h003, 16'h0000, 2'b00);
    step(0, 0, 0, 1, 12'h003, 16'h7777, 2'b11);
    step(0, 1, 1, 0, 12'h003, 16'h0000, 2'b00);
    idle(5);

    // Reset mid-flight discards pending reads
    step(0, 1, 1, 0, 12'h001, 16'h0000, 2'b00);
    step(0, 1, 1, 0, 12'h002, 16'h0000, 2'b00);
    step(1, 0, 0, 0, 12'h000, 16'h0000, 2'b00);
    idle(5);
`ifdef MEM_ACCESS_CHECK_EN
    check("access_err_cleared_by_reset", 16'(err_w[0]), 16'h0000);
`endif

    // Write during reset ignored; array contents kept across reset
    step(1, 1, 0, 1, 12'h009, 16'h9999, 2'b11);
    step(0, 1, 1, 0, 12'h009, 16'h0000, 2'b00);
    step(0, 1, 1, 0, 12'h005, 16'h0000, 2'b00);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
